// File: rtl/arc_mem_responder.sv
// ---------------------------------------------------------------------------
// arc_mem_responder
//   Word-addressed memory slave for the ARC datapath load/store bus. A request
//   is captured in IDLE. After a fixed number of wait cycles the block answers
//   with a one-cycle ack. Misaligned or out-of-range accesses are rejected:
//   they raise err together with ack and return zero read data.
//
// Ports
//   clk    in   1       system clock, rising edge
//   rst    in   1       asynchronous reset, active-low
//   req    in   1       request strobe, held by the initiator until ack
//   we     in   1       1 = store, 0 = load (sampled with req)
//   addr   in   32      byte address (sampled with req)
//   wdata  in   DATA_W  store data (sampled with req)
//   rdata  out  DATA_W  load data, valid with ack and held until the next ack
//   ack    out  1       one-cycle completion pulse
//   err    out  1       access rejected, only ever high together with ack
//   busy   out  1       high from request acceptance until ack drops
// ---------------------------------------------------------------------------
module arc_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,   // word-address width, at most 29
    parameter int LATENCY = 4     // 1..15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          count_reg, count_next;
    logic                we_reg, we_next;
    logic [31:0]         addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                ack_reg, ack_next;
    logic                err_reg, err_next;
    logic                busy_reg, busy_next;
    // When set, rdata reads as zero. This covers both the post-reset value and
    // rejected accesses. The RAM output register can then stay reset-free, which
    // lets it map onto the block RAM's own output register.
    logic                zero_reg, zero_next;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]   ram_q;

    logic                addr_ok;
    logic [ADDR_W-1:0]   word_idx;
    logic                fire;
    logic                mem_wr;
    logic                mem_rd;

    assign addr_ok  = (addr_reg[1:0] == 2'b00) && (addr_reg[31:ADDR_W+2] == '0);
    assign word_idx = addr_reg[ADDR_W+1:2];
    assign fire     = (state_reg == WAIT) && (count_reg == 4'd0);
    assign mem_wr   = fire &&  we_reg && addr_ok;
    assign mem_rd   = fire && !we_reg && addr_ok;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        ack_next   = ack_reg;
        err_next   = err_reg;
        busy_next  = busy_reg;
        zero_next  = zero_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    we_next    = we;
                    addr_next  = addr;
                    wdata_next = wdata;
                    // A count of zero skips the dwell entirely when LATENCY is 1.
                    count_next = 4'(LATENCY - 1);
                    busy_next  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = RESP;
                    ack_next   = 1'b1;
                    err_next   = !addr_ok;
                    // A store leaves rdata alone. A good load exposes the RAM
                    // word. A rejected access forces zero.
                    if (!addr_ok) begin
                        zero_next = 1'b1;
                    end else if (!we_reg) begin
                        zero_next = 1'b0;
                    end
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            RESP: begin
                ack_next   = 1'b0;
                err_next   = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                ack_next   = 1'b0;
                err_next   = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
            zero_reg  <= zero_next;
        end
    end

    // Single-port synchronous RAM. Its contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[word_idx] <= wdata_reg;
        end
        if (mem_rd) begin
            ram_q <= mem[word_idx];
        end
    end

    assign rdata = zero_reg ? '0 : ram_q;
    assign ack   = ack_reg;
    assign err   = err_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_arc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_arc_mem_responder
//   Bench for the ARC memory responder. It builds three instances with
//   LATENCY = 4, 1 and 7. It runs a reset check, a directed vector table, a
//   mid-operation reset, a latency sweep and a randomized run. The randomized
//   run is checked against a word-array reference model.
// ---------------------------------------------------------------------------
module tb_arc_mem_responder;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst;
    logic        req_s   [NDUT];
    logic        we_s    [NDUT];
    logic [31:0] addr_s  [NDUT];
    logic [31:0] wdata_s [NDUT];
    logic [31:0] rdata_s [NDUT];
    logic        ack_s   [NDUT];
    logic        err_s   [NDUT];
    logic        busy_s  [NDUT];

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model for instance 0: word array, written flags, last rdata.
    logic [31:0] model  [1024];
    bit          mvalid [1024];
    logic [31:0] last_rd;

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 7);
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            arc_mem_responder #(
                .DATA_W (32),
                .ADDR_W (10),
                .LATENCY((gi == 0) ? 4 : ((gi == 1) ? 1 : 7))
            ) u_dut (
                .clk  (clk),
                .rst  (rst),
                .req  (req_s[gi]),
                .we   (we_s[gi]),
                .addr (addr_s[gi]),
                .wdata(wdata_s[gi]),
                .rdata(rdata_s[gi]),
                .ack  (ack_s[gi]),
                .err  (err_s[gi]),
                .busy (busy_s[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // Runs one transaction on instance k and checks every observable.
    // With scramble set, the inputs are randomized during the wait to show
    // that the captured values are used.
    task automatic run_chk(input int k, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           input bit exp_err, input bit scramble);
        int  lat;
        int  bcnt;
        bit  acked;
        bit  width_ok;
        logic [31:0] rd;
        logic er;
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
        @(posedge clk); #1;
        lat = 0; acked = 0;
        bcnt = busy_s[k] ? 1 : 0;
        if (scramble) begin
            we_s[k]    = 1'($urandom);
            addr_s[k]  = $urandom;
            wdata_s[k] = $urandom;
            req_s[k]   = 1'($urandom);
        end
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy_s[k]) bcnt++;
            if (ack_s[k]) begin
                acked = 1;
                break;
            end
        end
        rd = rdata_s[k];
        er = err_s[k];
        req_s[k] = 1'b0;
        @(posedge clk); #1;
        width_ok = !ack_s[k] && !busy_s[k] && !err_s[k];
        $display("txn dut=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d busy=%0d",
                 k, w, a, d, rd, er, lat, bcnt);
        chk("ack_seen", 32'(acked), 32'd1);
        chk("latency", 32'(lat), 32'(lat_of(k)));
        chk("busy_cycles", 32'(bcnt), 32'(lat_of(k) + 1));
        chk("err", 32'(er), 32'(exp_err));
        chk("rdata", rd, exp_rd);
        chk("ack_width", 32'(width_ok), 32'd1);
        if (k == 0) begin
            last_rd = exp_rd;
            if (w && !exp_err) begin
                model[a[11:2]]  = d;
                mvalid[a[11:2]] = 1'b1;
            end
        end
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int nack;
        for (int i = 0; i < NDUT; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
        end
        for (int i = 0; i < 1024; i++) mvalid[i] = 1'b0;
        last_rd = '0;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_1003, 32'h5555_5555, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[10] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h1111_1111};

        // Reset held for 4 cycles while req is high.
        rst = 1'b0;
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("reset_ack", 32'(ack_s[0]), 32'd0);
            chk("reset_busy", 32'(busy_s[0]), 32'd0);
            chk("reset_rdata", rdata_s[0], 32'd0);
        end
        rst = 1'b1;
        run_chk(0, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);

        // Directed table, with inputs scrambled during the wait.
        for (int i = 0; i < 11; i++)
            run_chk(0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, 1'b1);

        // Reset during WAIT of a store to 0x20: no ack, and the store is dropped.
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'h2222_2222;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy_before", 32'(busy_s[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_s[0]), 32'd0);
        chk("midrst_ack", 32'(ack_s[0]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (ack_s[0]) nack++;
        end
        chk("midrst_no_ack", 32'(nack), 32'd0);
        last_rd = '0;
        run_chk(0, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, 1'b0);

        // Latency sweep on the LATENCY=1 and LATENCY=7 instances.
        for (int k = 1; k < NDUT; k++) begin
            run_chk(k, 1'b1, 32'h8, 32'h1234_5678 + 32'(k), 32'h0, 1'b0, 1'b0);
            run_chk(k, 1'b0, 32'h8, 32'h0, 32'h1234_5678 + 32'(k), 1'b0, 1'b0);
        end

        // Randomized back-to-back traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] erd;
            bit   w;
            bit   ok;
            int   r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = ($urandom_range(0, 63) << 2) | 32'($urandom_range(1, 3));
            else if (r == 1) a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
            else             a = 32'($urandom_range(0, 15)) << 2;
            d  = $urandom;
            w  = 1'($urandom);
            ok = (a[1:0] == 2'b00) && (a[31:12] == 20'h0);
            if (ok && !w && !mvalid[a[11:2]]) w = 1'b1;
            if (!ok)    erd = 32'h0;
            else if (w) erd = last_rd;
            else        erd = model[a[11:2]];
            run_chk(0, w, a, d, erd, !ok, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
